// File: rtl/vram_responder.sv
// vram_responder: serves video word-pair fetches from byte-wide VRAM
// and arbitrates a req/ack CPU byte port onto it; video has priority.
module vram_responder #(
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vram_addr1,
  input  logic [ADDR_W-1:0] vram_addr2,
  output logic [15:0]       vram_dout1,
  output logic [15:0]       vram_dout2,
  output logic              vid_done,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [3:0] {
    IDLE, V0, V1, V2, V3, VW,
    C_ISS, C_WAIT, C_ACK
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] cap_a1, cap_a2;
  logic              vid_pend;

  logic [ADDR_W-1:0] addr_nx;
  logic              we_nx;
  logic [7:0]        wd_nx;

  logic [7:0] b0, b1, b2;

  logic       iss_v;
  logic [2:0] iss_k;
  logic       p1_v, p2_v, p1_rd, p2_rd;
  logic [2:0] p1_k, p2_k;
  logic       o_v, o_rd;
  logic [2:0] o_k;

  logic vbusy, vid_acc, vid_go, cpu_go;
  logic last_byte, cpu_fin;

  assign vbusy   = state inside {V0, V1, V2, V3, VW};
  assign vid_acc = vid_req & ~vid_pend & ~vbusy;
  assign vid_go  = vid_pend | vid_req;
  assign cpu_go  = cpu_req & ~cpu_ack;

  // Tag of the memory access presented this cycle (4 = CPU access)
  always_comb begin
    iss_v = 1'b1;
    iss_k = 3'd4;
    unique case (state)
      V0:      iss_k = 3'd0;
      V1:      iss_k = 3'd1;
      V2:      iss_k = 3'd2;
      V3:      iss_k = 3'd3;
      C_ISS:   iss_k = 3'd4;
      default: iss_v = 1'b0;
    endcase
  end

  assign o_v  = (RD_LAT == 2) ? p2_v  : p1_v;
  assign o_k  = (RD_LAT == 2) ? p2_k  : p1_k;
  assign o_rd = (RD_LAT == 2) ? p2_rd : p1_rd;

  assign last_byte = o_v & (o_k == 3'd3);
  assign cpu_fin   = o_v & (o_k == 3'd4);

  // Next state and next memory command; video beats CPU
  always_comb begin
    state_nx = state;
    addr_nx  = mem_addr;
    we_nx    = 1'b0;
    wd_nx    = mem_wdata;
    unique case (state)
      IDLE, C_ACK: begin
        if (vid_go) begin
          state_nx = V0;
          addr_nx  = vid_pend ? cap_a1 : vram_addr1;
        end else if (cpu_go) begin
          state_nx = C_ISS;
          addr_nx  = cpu_addr;
          we_nx    = cpu_we;
          wd_nx    = cpu_din;
        end else begin
          state_nx = IDLE;
        end
      end
      V0: begin
        state_nx = V1;
        addr_nx  = cap_a1 + 1'b1;
      end
      V1: begin
        state_nx = V2;
        addr_nx  = cap_a2;
      end
      V2: begin
        state_nx = V3;
        addr_nx  = cap_a2 + 1'b1;
      end
      V3:      state_nx = VW;
      VW:      if (last_byte) state_nx = IDLE;
      C_ISS:   state_nx = C_WAIT;
      C_WAIT:  if (cpu_fin) state_nx = C_ACK;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Registered memory command; write strobe lasts one cycle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
    end else begin
      mem_addr  <= addr_nx;
      mem_we    <= we_nx;
      mem_wdata <= wd_nx;
    end
  end

  // Return-tag pipeline aligning read data with its access
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_v  <= 1'b0;
      p1_k  <= 3'd0;
      p1_rd <= 1'b0;
      p2_v  <= 1'b0;
      p2_k  <= 3'd0;
      p2_rd <= 1'b0;
    end else begin
      p1_v  <= iss_v;
      p1_k  <= iss_k;
      p1_rd <= (state == C_ISS) & ~mem_we;
      p2_v  <= p1_v;
      p2_k  <= p1_k;
      p2_rd <= p1_rd;
    end
  end

  // Video request capture, byte assembly and atomic result update
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cap_a1      <= '0;
      cap_a2      <= '0;
      vid_pend    <= 1'b0;
      vid_overrun <= 1'b0;
      vid_done    <= 1'b0;
      b0          <= 8'h00;
      b1          <= 8'h00;
      b2          <= 8'h00;
      vram_dout1  <= 16'h0000;
      vram_dout2  <= 16'h0000;
    end else begin
      vid_done <= 1'b0;
      if (vid_acc) begin
        cap_a1   <= vram_addr1;
        cap_a2   <= vram_addr2;
        vid_pend <= 1'b1;
      end else if (vid_req) begin
        vid_overrun <= 1'b1;
      end
      if (o_v) begin
        unique case (1'b1)
          o_k == 3'd0: b0 <= mem_rdata;
          o_k == 3'd1: b1 <= mem_rdata;
          o_k == 3'd2: b2 <= mem_rdata;
          o_k == 3'd3: begin
            vram_dout1 <= {b1, b0};
            vram_dout2 <= {mem_rdata, b2};
            vid_done   <= 1'b1;
            vid_pend   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // CPU completion, read data and 4-phase ack
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout <= 8'h00;
      cpu_ack  <= 1'b0;
    end else if (cpu_fin) begin
      if (o_rd)    cpu_dout <= mem_rdata;
      if (cpu_req) cpu_ack  <= 1'b1;
    end else if (cpu_ack && !cpu_req) begin
      cpu_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_responder.sv
// tb_vram_responder: directed bench, two DUTs (RD_LAT 1 and 2)
// each with its own byte memory model; one is observed per pass.
module tb_vram_responder;

  localparam int AW = 19;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          vid_req;
  logic [AW-1:0] vram_addr1, vram_addr2;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;

  logic [15:0]   a_dout1, a_dout2, b_dout1, b_dout2;
  logic          a_done, b_done, a_ovr, b_ovr;
  logic [7:0]    a_cdout, b_cdout;
  logic          a_ack, b_ack;
  logic [AW-1:0] a_maddr, b_maddr;
  logic          a_we, b_we;
  logic [7:0]    a_wd, b_wd;
  logic [7:0]    a_q1, b_q1, b_q2;

  logic [7:0] mem_a [0:(1<<AW)-1];
  logic [7:0] mem_b [0:(1<<AW)-1];

  logic sel;
  int   lat;
  int   n_chk;
  int   n_err;

  logic [15:0]   s_dout1, s_dout2;
  logic          s_done, s_ovr, s_ack, s_we;
  logic [7:0]    s_cdout;
  logic [AW-1:0] s_maddr;

  always #5 clk_sys = ~clk_sys;

  vram_responder #(.ADDR_W(AW), .RD_LAT(1)) u_dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vid_req(vid_req),
    .vram_addr1(vram_addr1), .vram_addr2(vram_addr2),
    .vram_dout1(a_dout1), .vram_dout2(a_dout2),
    .vid_done(a_done), .vid_overrun(a_ovr),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(a_cdout), .cpu_ack(a_ack),
    .mem_addr(a_maddr), .mem_we(a_we),
    .mem_wdata(a_wd), .mem_rdata(a_q1)
  );

  vram_responder #(.ADDR_W(AW), .RD_LAT(2)) u_dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vid_req(vid_req),
    .vram_addr1(vram_addr1), .vram_addr2(vram_addr2),
    .vram_dout1(b_dout1), .vram_dout2(b_dout2),
    .vid_done(b_done), .vid_overrun(b_ovr),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(b_cdout), .cpu_ack(b_ack),
    .mem_addr(b_maddr), .mem_we(b_we),
    .mem_wdata(b_wd), .mem_rdata(b_q2)
  );

  always @(posedge clk_sys) begin
    a_q1 <= mem_a[a_maddr];
    if (a_we) mem_a[a_maddr] <= a_wd;
  end

  always @(posedge clk_sys) begin
    b_q1 <= mem_b[b_maddr];
    b_q2 <= b_q1;
    if (b_we) mem_b[b_maddr] <= b_wd;
  end

  assign s_dout1 = sel ? b_dout1 : a_dout1;
  assign s_dout2 = sel ? b_dout2 : a_dout2;
  assign s_done  = sel ? b_done  : a_done;
  assign s_ovr   = sel ? b_ovr   : a_ovr;
  assign s_ack   = sel ? b_ack   : a_ack;
  assign s_we    = sel ? b_we    : a_we;
  assign s_cdout = sel ? b_cdout : a_cdout;
  assign s_maddr = sel ? b_maddr : a_maddr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (RD_LAT=%0d): got %0h expected %0h",
               tag, lat, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    check({tag, "_dout1"}, 32'(s_dout1), 32'h0);
    check({tag, "_dout2"}, 32'(s_dout2), 32'h0);
    check({tag, "_done"},  32'(s_done),  32'h0);
    check({tag, "_ovr"},   32'(s_ovr),   32'h0);
    check({tag, "_ack"},   32'(s_ack),   32'h0);
    check({tag, "_cdout"}, 32'(s_cdout), 32'h0);
    check({tag, "_maddr"}, 32'(s_maddr), 32'h0);
    check({tag, "_we"},    32'(s_we),    32'h0);
  endtask

  task automatic vid_fetch(input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2,
                           input logic [15:0]   e1,
                           input logic [15:0]   e2);
    logic [AW-1:0] ea [4];
    int dn;
    int n;
    ea[0] = a1;
    ea[1] = a1 + 19'd1;
    ea[2] = a2;
    ea[3] = a2 + 19'd1;
    vid_req    = 1'b1;
    vram_addr1 = a1;
    vram_addr2 = a2;
    tick();
    vid_req = 1'b0;
    dn = 0;
    for (n = 1; n <= 20; n++) begin
      if (n <= 4)
        check("vid_maddr", 32'(s_maddr), 32'(ea[n-1]));
      if (s_done) begin
        dn = n;
        break;
      end
      tick();
    end
    check("vid_lat",   32'(dn),      32'(5 + lat));
    check("vid_dout1", 32'(s_dout1), 32'(e1));
    check("vid_dout2", 32'(s_dout2), 32'(e2));
    tick();
    check("vid_pulse", 32'(s_done),  32'h0);
  endtask

  task automatic cpu_access(input logic          we,
                            input logic [AW-1:0] addr,
                            input logic [7:0]    din,
                            input logic [7:0]    edout);
    int k;
    int nwe;
    logic got;
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
    nwe = 0;
    got = 1'b0;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (s_we) begin
        nwe++;
        check("cpu_waddr", 32'(s_maddr), 32'(addr));
      end
      if (s_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("cpu_ack", 32'(got), 32'h1);
    check("cpu_lat", 32'(k),   32'(2 + lat));
    if (!we) check("cpu_dout", 32'(s_cdout), 32'(edout));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_we) nwe++;
      check("cpu_ack_hold", 32'(s_ack), 32'h1);
    end
    check("cpu_nwe", 32'(nwe), 32'(we));
    cpu_req = 1'b0;
    tick();
    check("cpu_ack_drop", 32'(s_ack), 32'h0);
    tick();
  endtask

  initial begin
    int vd, wn, an, cnt;
    reset_n    = 1'b0;
    vid_req    = 1'b0;
    vram_addr1 = '0;
    vram_addr2 = '0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_din    = 8'h00;
    sel        = 1'b0;
    lat        = 1;
    n_chk      = 0;
    n_err      = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] <= 8'(i);
      mem_b[i] <= 8'(i);
    end

    for (int p = 0; p < 2; p++) begin
      sel     = (p == 1);
      lat     = p + 1;
      reset_n = 1'b0;
      tick();
      tick();
      rst_chk("reset");
      reset_n = 1'b1;
      tick();
      tick();

      vid_fetch(19'h00100, 19'h06100, 16'h0100, 16'h0100);
      vid_fetch(19'h7FFFF, 19'h00003, 16'h00FF, 16'h0403);

      cpu_access(1'b1, 19'h00200, 8'h5A, 8'h00);
      cpu_access(1'b0, 19'h00200, 8'h00, 8'h5A);

      // video and CPU requested in the same idle cycle
      vid_req    = 1'b1;
      vram_addr1 = 19'h00100;
      vram_addr2 = 19'h06100;
      cpu_req    = 1'b1;
      cpu_we     = 1'b1;
      cpu_addr   = 19'h00300;
      cpu_din    = 8'hA5;
      tick();
      vid_req = 1'b0;
      vd = 0;
      wn = 0;
      an = 0;
      for (int n = 1; n <= 30; n++) begin
        if (s_done && vd == 0) vd = n;
        if (s_we && wn == 0)   wn = n;
        if (s_ack) begin
          an = n;
          break;
        end
        tick();
      end
      check("sim_vid_lat", 32'(vd), 32'(5 + lat));
      check("sim_cpu_iss", 32'(wn), 32'(6 + lat));
      check("sim_cpu_ack", 32'(an), 32'(7 + 2 * lat));
      check("sim_dout1",   32'(s_dout1), 32'h0100);
      cpu_req = 1'b0;
      tick();
      tick();
      cpu_access(1'b0, 19'h00300, 8'h00, 8'hA5);

      // second request while the first is in flight
      check("ovr_pre", 32'(s_ovr), 32'h0);
      vid_req    = 1'b1;
      vram_addr1 = 19'h00100;
      vram_addr2 = 19'h06100;
      tick();
      cnt = 0;
      vd  = 0;
      for (int n = 1; n <= 16; n++) begin
        vid_req = (n == 3);
        if (n == 3) begin
          vram_addr1 = 19'h00200;
          vram_addr2 = 19'h00200;
        end
        if (s_done) begin
          cnt++;
          if (vd == 0) vd = n;
        end
        tick();
      end
      vid_req = 1'b0;
      check("ovr_ndone", 32'(cnt),     32'h1);
      check("ovr_lat",   32'(vd),      32'(5 + lat));
      check("ovr_dout1", 32'(s_dout1), 32'h0100);
      check("ovr_dout2", 32'(s_dout2), 32'h0100);
      check("ovr_flag",  32'(s_ovr),   32'h1);

      // reset while issuing byte 2 of a fetch
      vid_req    = 1'b1;
      vram_addr1 = 19'h00100;
      vram_addr2 = 19'h06100;
      tick();
      vid_req = 1'b0;
      tick();
      tick();
      check("v2_maddr", 32'(s_maddr), 32'h06100);
      reset_n = 1'b0;
      #1;
      rst_chk("rst_v2");
      #2;
      reset_n = 1'b1;
      tick();
      tick();
      vid_fetch(19'h7FFFF, 19'h00003, 16'h00FF, 16'h0403);

      // reset during a CPU write issue cycle
      cpu_req  = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = 19'h004C7;
      cpu_din  = 8'h77;
      tick();
      check("ciss_we",    32'(s_we),    32'h1);
      check("ciss_maddr", 32'(s_maddr), 32'h004C7);
      reset_n = 1'b0;
      #1;
      rst_chk("rst_ciss");
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
      tick();
      cpu_access(1'b0, 19'h004C7, 8'h00, 8'hC7);
      vid_fetch(19'h00100, 19'h06100, 16'h0100, 16'h0100);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
